// File: rtl/gpu_sram_pkg.sv
// Shared types for the GPU-side asynchronous SRAM controller: FSM states,
// access-source encoding and default bus widths.
package gpu_sram_pkg;

    localparam int unsigned DEF_ADDR_W = 18;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdSample,
        StWrStrobe,
        StWrHold,
        StAck
    } state_e;

    typedef enum logic [1:0] {
        SrcVga   = 2'd0,
        SrcGpu   = 2'd1,
        SrcDrain = 2'd2
    } src_e;

endpackage

// File: rtl/gpu_sram_wbuf.sv
// One-entry posted write buffer: address/data register with a full flag,
// filled by load and emptied by pop.
module gpu_sram_wbuf
    import gpu_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              pop,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/gpu_sram_ctrl.sv
// GPU/VGA responder for the board's asynchronous 16-bit SRAM.
// Define GPU_SRAM_WRITE_BUFFER_EN to add a one-entry posted write buffer.
module gpu_sram_ctrl
    import gpu_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_VIDEO_ON,
    input  logic [ADDR_W-1:0] I_GPU_ADDR,
    input  logic [DATA_W-1:0] I_GPU_DATA,
    input  logic              I_GPU_READ,
    input  logic              I_GPU_WRITE,
    output logic [DATA_W-1:0] O_GPU_DATA,
    output logic              O_GPU_ACK,
    input  logic [ADDR_W-1:0] I_VGA_ADDR,
    input  logic              I_VGA_READ,
    output logic [DATA_W-1:0] O_VGA_DATA,
    output logic              O_VGA_VALID,
    output logic [ADDR_W-1:0] O_SRAM_ADDR,
    output logic [DATA_W-1:0] O_SRAM_DQ,
    output logic              O_SRAM_DQ_OE,
    input  logic [DATA_W-1:0] I_SRAM_DQ,
    output logic              O_SRAM_CE_N,
    output logic              O_SRAM_OE_N,
    output logic              O_SRAM_WE_N,
    output logic              O_SRAM_UB_N,
    output logic              O_SRAM_LB_N
);

    state_e            state;
    src_e              src;
    logic              vga_req;
    logic              post_ack;
    logic              wb_load;
    logic              wb_pop;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    assign vga_req = I_VIDEO_ON && I_VGA_READ;

`ifdef GPU_SRAM_WRITE_BUFFER_EN
    logic wb_full;

    // A full buffer always drains before any GPU access, which keeps
    // read-after-write coherent without address comparison.
    always_comb begin
        wb_load = 1'b0;
        wb_pop  = 1'b0;
        if (state == StIdle && !post_ack && !vga_req) begin
            if (wb_full) begin
                wb_pop = 1'b1;
            end else if (I_GPU_WRITE) begin
                wb_load = 1'b1;
            end
        end
    end

    gpu_sram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk       (I_CLK),
        .rst_n     (I_RST_N),
        .load      (wb_load),
        .pop       (wb_pop),
        .load_addr (I_GPU_ADDR),
        .load_data (I_GPU_DATA),
        .full      (wb_full),
        .addr      (wb_addr),
        .data      (wb_data)
    );
`else
    assign wb_load = 1'b0;
    assign wb_pop  = 1'b0;
    assign wb_addr = '0;
    assign wb_data = '0;
`endif

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state        <= StIdle;
            src          <= SrcGpu;
            post_ack     <= 1'b0;
            O_SRAM_ADDR  <= '0;
            O_SRAM_DQ    <= '0;
            O_SRAM_DQ_OE <= 1'b0;
            O_SRAM_CE_N  <= 1'b1;
            O_SRAM_OE_N  <= 1'b1;
            O_SRAM_WE_N  <= 1'b1;
            O_SRAM_UB_N  <= 1'b1;
            O_SRAM_LB_N  <= 1'b1;
            O_GPU_DATA   <= '0;
            O_GPU_ACK    <= 1'b0;
            O_VGA_DATA   <= '0;
            O_VGA_VALID  <= 1'b0;
        end else begin
            O_GPU_ACK   <= 1'b0;
            O_VGA_VALID <= 1'b0;
            unique case (state)
                StIdle: begin
                    // A posted write spends one cycle latched before its ack.
                    if (post_ack) begin
                        post_ack  <= 1'b0;
                        O_GPU_ACK <= 1'b1;
                        state     <= StAck;
                    end else if (vga_req) begin
                        src         <= SrcVga;
                        O_SRAM_ADDR <= I_VGA_ADDR;
                        O_SRAM_CE_N <= 1'b0;
                        O_SRAM_OE_N <= 1'b0;
                        O_SRAM_UB_N <= 1'b0;
                        O_SRAM_LB_N <= 1'b0;
                        state       <= StRdAddr;
                    end else if (wb_pop) begin
                        src          <= SrcDrain;
                        O_SRAM_ADDR  <= wb_addr;
                        O_SRAM_DQ    <= wb_data;
                        O_SRAM_DQ_OE <= 1'b1;
                        O_SRAM_CE_N  <= 1'b0;
                        O_SRAM_WE_N  <= 1'b0;
                        O_SRAM_UB_N  <= 1'b0;
                        O_SRAM_LB_N  <= 1'b0;
                        state        <= StWrStrobe;
                    end else if (wb_load) begin
                        src      <= SrcGpu;
                        post_ack <= 1'b1;
                    end else if (I_GPU_WRITE) begin
                        src          <= SrcGpu;
                        O_SRAM_ADDR  <= I_GPU_ADDR;
                        O_SRAM_DQ    <= I_GPU_DATA;
                        O_SRAM_DQ_OE <= 1'b1;
                        O_SRAM_CE_N  <= 1'b0;
                        O_SRAM_WE_N  <= 1'b0;
                        O_SRAM_UB_N  <= 1'b0;
                        O_SRAM_LB_N  <= 1'b0;
                        state        <= StWrStrobe;
                    end else if (I_GPU_READ) begin
                        src         <= SrcGpu;
                        O_SRAM_ADDR <= I_GPU_ADDR;
                        O_SRAM_CE_N <= 1'b0;
                        O_SRAM_OE_N <= 1'b0;
                        O_SRAM_UB_N <= 1'b0;
                        O_SRAM_LB_N <= 1'b0;
                        state       <= StRdAddr;
                    end
                end
                StRdAddr: begin
                    state <= StRdSample;
                end
                StRdSample: begin
                    if (src == SrcVga) begin
                        O_VGA_DATA  <= I_SRAM_DQ;
                        O_VGA_VALID <= 1'b1;
                    end else begin
                        O_GPU_DATA <= I_SRAM_DQ;
                        O_GPU_ACK  <= 1'b1;
                    end
                    O_SRAM_CE_N <= 1'b1;
                    O_SRAM_OE_N <= 1'b1;
                    O_SRAM_UB_N <= 1'b1;
                    O_SRAM_LB_N <= 1'b1;
                    state       <= StAck;
                end
                StWrStrobe: begin
                    // WE_N rises here while address, data and DQ drive stay put.
                    O_SRAM_WE_N <= 1'b1;
                    state       <= StWrHold;
                end
                StWrHold: begin
                    O_SRAM_DQ_OE <= 1'b0;
                    O_SRAM_CE_N  <= 1'b1;
                    O_SRAM_UB_N  <= 1'b1;
                    O_SRAM_LB_N  <= 1'b1;
                    O_GPU_ACK    <= (src == SrcGpu);
                    state        <= StAck;
                end
                StAck: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_sram_ctrl.sv
// Self-checking bench for gpu_sram_ctrl with a behavioural SRAM and a
// transaction-level shadow memory; works with or without GPU_SRAM_WRITE_BUFFER_EN.
module tb_gpu_sram_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
`ifdef GPU_SRAM_WRITE_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          video_on;
    logic [AW-1:0] gpu_addr;
    logic [DW-1:0] gpu_wdata;
    logic          gpu_read;
    logic          gpu_write;
    logic [DW-1:0] gpu_rdata;
    logic          gpu_ack;
    logic [AW-1:0] vga_addr;
    logic          vga_read;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_in;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic          ub_n;
    logic          lb_n;

    int checks = 0;
    int errors = 0;
    int vga_cnt = 0;
    int we_run = 0;
    logic prev_ack = 1'b0;

    gpu_sram_ctrl dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .I_VIDEO_ON   (video_on),
        .I_GPU_ADDR   (gpu_addr),
        .I_GPU_DATA   (gpu_wdata),
        .I_GPU_READ   (gpu_read),
        .I_GPU_WRITE  (gpu_write),
        .O_GPU_DATA   (gpu_rdata),
        .O_GPU_ACK    (gpu_ack),
        .I_VGA_ADDR   (vga_addr),
        .I_VGA_READ   (vga_read),
        .O_VGA_DATA   (vga_data),
        .O_VGA_VALID  (vga_valid),
        .O_SRAM_ADDR  (sram_addr),
        .O_SRAM_DQ    (sram_dq),
        .O_SRAM_DQ_OE (sram_dq_oe),
        .I_SRAM_DQ    (sram_dq_in),
        .O_SRAM_CE_N  (ce_n),
        .O_SRAM_OE_N  (oe_n),
        .O_SRAM_WE_N  (we_n),
        .O_SRAM_UB_N  (ub_n),
        .O_SRAM_LB_N  (lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of every SRAM word, so reads of unwritten words are known.
    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], 14'h0A5C};
    endfunction

    // Behavioural asynchronous SRAM: latches data on the rising edge of WE_N.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    bit            written  [0:(1<<AW)-1];

    assign sram_dq_in = (!ce_n && !oe_n)
                      ? (written[sram_addr] ? sram_mem[sram_addr] : init_pat(sram_addr))
                      : 16'hDEAD;

    initial begin
        forever begin
            @(posedge we_n);
            if (ce_n === 1'b0) begin
                sram_mem[sram_addr] = sram_dq;
                written[sram_addr]  = 1'b1;
            end
        end
    end

    // Shadow of what the GPU believes memory holds.
    logic [DW-1:0] exp_mem [int];

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
        return init_pat(a);
    endfunction

    function automatic int exp_lat(input bit wr, input bit pend);
        int base;
        base = wr ? (BUF ? 2 : 3) : 3;
        return base + (pend ? 4 : 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 32'h0);
        chk({tag, "_sram_dq"}, 32'(sram_dq), 32'h0);
        chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'h0);
        chk({tag, "_gpu_data"}, 32'(gpu_rdata), 32'h0);
        chk({tag, "_gpu_ack"}, 32'(gpu_ack), 32'h0);
        chk({tag, "_vga_data"}, 32'(vga_data), 32'h0);
        chk({tag, "_vga_valid"}, 32'(vga_valid), 32'h0);
    endtask

    // Protocol monitor: write strobe width, bus direction and ack pulse width.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (we_n === 1'b0) begin
                    we_run++;
                    chk("wr_oe_n_high", 32'(oe_n), 32'h1);
                    chk("wr_dq_oe", 32'(sram_dq_oe), 32'h1);
                end else if (we_run != 0) begin
                    chk("we_low_cycles", 32'(we_run), 32'h1);
                    we_run = 0;
                end
                if (gpu_ack === 1'b1) chk("ack_one_cycle", 32'(prev_ack), 32'h0);
                if (vga_valid === 1'b1) vga_cnt++;
            end
            prev_ack = gpu_ack;
        end
    end

    // One GPU access from a negedge; leaves one idle cycle after the ack.
    task automatic gpu_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int lat);
        gpu_addr  = a;
        gpu_wdata = d;
        gpu_write = wr;
        gpu_read  = !wr;
        lat = 0;
        rd  = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gpu_ack === 1'b1) begin
                lat = c;
                rd  = gpu_rdata;
                break;
            end
        end
        gpu_write = 1'b0;
        gpu_read  = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL gpu_ack_timeout: no ack for addr 0x%0h within 40 cycles", a);
        end
        if (wr) exp_mem[int'(a)] = d;
        @(negedge clk);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] vdat;
        logic [DW-1:0] gdat;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int lat;
        int vlat;
        int glat;
        int cnt0;
        int acks;
        bit pend;
        bit wr;
        bit ok;

        vecs[0]  = '{1'b1, 18'h00010, 16'h1234, 16'h0000};
        vecs[1]  = '{1'b0, 18'h00010, 16'h0000, 16'h1234};
        vecs[2]  = '{1'b1, 18'h3FFFF, 16'hFFFF, 16'h0000};
        vecs[3]  = '{1'b0, 18'h3FFFF, 16'h0000, 16'hFFFF};
        vecs[4]  = '{1'b1, 18'h00000, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 18'h00000, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b1, 18'h2AAAA, 16'hA5A5, 16'h0000};
        vecs[7]  = '{1'b1, 18'h15555, 16'h5A5A, 16'h0000};
        vecs[8]  = '{1'b0, 18'h2AAAA, 16'h0000, 16'hA5A5};
        vecs[9]  = '{1'b0, 18'h15555, 16'h0000, 16'h5A5A};
        vecs[10] = '{1'b0, 18'h00010, 16'h0000, 16'h1234};
        vecs[11] = '{1'b0, 18'h00100, 16'h0000, 16'h0B5C};

        rst_n     = 1'b0;
        video_on  = 1'b0;
        gpu_addr  = '0;
        gpu_wdata = '0;
        gpu_read  = 1'b0;
        gpu_write = 1'b0;
        vga_addr  = '0;
        vga_read  = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table of writes and reads, one idle cycle apart.
        pend = 1'b0;
        for (int i = 0; i < 12; i++) begin
            gpu_op(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].wr, pend)));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp));
            pend = BUF && vecs[i].wr;
        end

        // VGA and GPU read raised together with video on: VGA goes first.
        video_on = 1'b1;
        vga_addr = 18'h00020;
        vga_read = 1'b1;
        gpu_addr = 18'h00030;
        gpu_read = 1'b1;
        vlat = 0;
        glat = 0;
        vdat = '0;
        gdat = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (vga_valid === 1'b1 && vlat == 0) begin
                vlat     = c;
                vdat     = vga_data;
                vga_read = 1'b0;
            end
            if (gpu_ack === 1'b1) begin
                glat = c;
                gdat = gpu_rdata;
                break;
            end
        end
        gpu_read = 1'b0;
        vga_read = 1'b0;
        video_on = 1'b0;
        @(negedge clk);
        chk("vga_prio_lat", 32'(vlat), 32'd3);
        chk("vga_prio_data", 32'(vdat), 32'(exp_rd(18'h00020)));
        chk("gpu_after_vga_lat", 32'(glat), 32'd7);
        chk("gpu_after_vga_data", 32'(gdat), 32'(exp_rd(18'h00030)));

        // VGA request with video off must be ignored.
        cnt0     = vga_cnt;
        vga_addr = 18'h00040;
        vga_read = 1'b1;
        gpu_op(1'b0, 18'h00050, 16'h0, rd, lat);
        chk("video_off_gpu_lat", 32'(lat), 32'd3);
        chk("video_off_gpu_data", 32'(rd), 32'(exp_rd(18'h00050)));
        repeat (4) @(negedge clk);
        chk("video_off_no_valid", 32'(vga_cnt), 32'(cnt0));
        chk("vga_data_held", 32'(vga_data), 32'(vdat));
        vga_read = 1'b0;

        // Write then immediate read of the same word.
        gpu_op(1'b1, 18'h00005, 16'hBEEF, rd, lat);
        chk("beef_wr_lat", 32'(lat), 32'(exp_lat(1'b1, 1'b0)));
        gpu_op(1'b0, 18'h00005, 16'h0, rd, lat);
        chk("beef_rd_lat", 32'(lat), 32'(exp_lat(1'b0, BUF)));
        chk("beef_rd_data", 32'(rd), 32'h0000BEEF);

        // Read and write both high: write served, read follows.
        gpu_op(1'b1, 18'h00200, 16'h1111, rd, lat);
        chk("pre_both_wr_lat", 32'(lat), 32'(exp_lat(1'b1, 1'b0)));
        gpu_addr  = 18'h00200;
        gpu_wdata = 16'h7777;
        gpu_write = 1'b1;
        gpu_read  = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gpu_ack === 1'b1) begin
                lat = c;
                break;
            end
        end
        gpu_write = 1'b0;
        exp_mem[int'(18'h00200)] = 16'h7777;
        chk("both_first_ack_lat", 32'(lat), 32'(exp_lat(1'b1, BUF)));
        rd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gpu_ack === 1'b1) begin
                rd = gpu_rdata;
                break;
            end
        end
        gpu_read = 1'b0;
        @(negedge clk);
        chk("both_read_data", 32'(rd), 32'h00007777);

        // Randomized traffic against the shadow memory; stray VGA requests with video off.
        cnt0 = vga_cnt;
        for (int n = 0; n < 60; n++) begin
            vga_read = 1'($urandom);
            vga_addr = 18'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wr = 1'($urandom);
            a  = {2'($urandom), 13'd0, 3'($urandom)};
            d  = 16'($urandom);
            if (!wr) begin
                gdat = exp_rd(a);
            end
            gpu_op(wr, a, d, rd, lat);
            ok = BUF ? (lat >= 2 && lat <= 15) : (lat == 3);
            chk($sformatf("rand%0d_lat", n), 32'(ok), 32'h1);
            if (!wr) chk($sformatf("rand%0d_rdata", n), 32'(rd), 32'(gdat));
        end
        vga_read = 1'b0;
        chk("rand_no_vga_valid", 32'(vga_cnt), 32'(cnt0));

        // A read forces any posted write out before the reset test.
        gpu_op(1'b0, 18'h00010, 16'h0, rd, lat);
        chk("flush_rd_data", 32'(rd), 32'h00001234);

        // Reset pulsed while the read sits in RD_SAMPLE.
        gpu_addr = 18'h00010;
        gpu_read = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        gpu_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (gpu_ack === 1'b1) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'h0);

        gpu_op(1'b0, 18'h00010, 16'h0, rd, lat);
        chk("post_rst_rd_lat", 32'(lat), 32'd3);
        chk("post_rst_rd_data", 32'(rd), 32'h00001234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
